ir_nec_decoder: RTL

- Decodes a demodulated NEC-format 32-bit IR frame from a receiver module output into a parallel word.
- Implements the frame layout the IR transmitter path produces. Sits beside it inside the IR transceiver subsystem.
- Input is active-low: 0 = carrier burst (mark), 1 = no burst (space).
- Measures every mark and space in clock cycles, classifies it against unit-based windows, and assembles bits LSB first.

---
 rtl/ir_pkg.sv | 40 ++++
 rtl/ir_input_sync.sv | 31 +++
 rtl/ir_nec_decoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared NEC IR protocol definitions: FSM states, unit multipliers and
// receive window bounds (in half-units so U/2 bounds stay integral).
package ir_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK,
      STOP_MARK_REPEAT
   } ir_state_t;

   localparam int LEAD_MARK_UNITS    = 16;
   localparam int LEAD_SPACE_UNITS   = 8;
   localparam int REPEAT_SPACE_UNITS = 4;
   localparam int ONE_SPACE_UNITS    = 3;
   localparam int BIT_MARK_UNITS     = 1;
   localparam int FRAME_BITS         = 32;

   localparam int LEAD_MARK_MIN_H   = 28;
   localparam int LEAD_MARK_MAX_H   = 36;
   localparam int LEAD_SPACE_MIN_H  = 14;
   localparam int LEAD_SPACE_MAX_H  = 18;
   localparam int REPEAT_SPACE_MIN_H = 6;
   localparam int REPEAT_SPACE_MAX_H = 10;
   localparam int BIT_MARK_MIN_H    = 1;
   localparam int BIT_MARK_MAX_H    = 4;
   localparam int ZERO_SPACE_MIN_H  = 1;
   localparam int ONE_SPACE_MIN_H   = 4;
   localparam int ONE_SPACE_MAX_H   = 8;
   localparam int STOP_MARK_MIN_H   = 1;
   localparam int STOP_MARK_MAX_H   = 4;

   function automatic int h2clk(input int half_units, input int clk_per_unit);
      return (half_units * clk_per_unit) / 2;
   endfunction

endpackage

// File: rtl/ir_input_sync.sv
// Two-flop synchronizer for the asynchronous IR line plus a previous-sample
// register; reports mark start (fall), mark end (rise) and the synced level.
module ir_input_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic rx_port,
   output logic fall,
   output logic rise,
   output logic level
);

   logic sync_1, sync_2, prev;

   // Idle line is a space, so every stage resets high.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         prev   <= 1'b1;
      end else begin
         sync_1 <= rx_port;
         sync_2 <= sync_1;
         prev   <= sync_2;
      end
   end

   assign fall  = prev & ~sync_2;
   assign rise  = ~prev & sync_2;
   assign level = sync_2;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: measures mark/space widths and assembles 32 bits LSB first.
// Define IR_NEC_REPEAT_EN to add the rx_repeat output for NEC repeat codes.
module ir_nec_decoder
   import ir_pkg::*;
#(
   parameter int CLK_PER_UNIT  = 28125,
   parameter int TIMEOUT_UNITS = 20
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx_enable,
   input  logic        rx_port,
   output logic        rx_valid,
   output logic [31:0] rx_data,
   output logic        rx_error
`ifdef IR_NEC_REPEAT_EN
   ,
   output logic        rx_repeat
`endif
);

   localparam int CNT_MAX_I = TIMEOUT_UNITS * CLK_PER_UNIT + 1;
   localparam int CW        = $clog2(CNT_MAX_I + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(CNT_MAX_I);

   localparam int LM_LO = h2clk(LEAD_MARK_MIN_H, CLK_PER_UNIT);
   localparam int LM_HI = h2clk(LEAD_MARK_MAX_H, CLK_PER_UNIT);
   localparam int LS_LO = h2clk(LEAD_SPACE_MIN_H, CLK_PER_UNIT);
   localparam int LS_HI = h2clk(LEAD_SPACE_MAX_H, CLK_PER_UNIT);
   localparam int BM_LO = h2clk(BIT_MARK_MIN_H, CLK_PER_UNIT);
   localparam int BM_HI = h2clk(BIT_MARK_MAX_H, CLK_PER_UNIT);
   localparam int Z_LO  = h2clk(ZERO_SPACE_MIN_H, CLK_PER_UNIT);
   localparam int O_LO  = h2clk(ONE_SPACE_MIN_H, CLK_PER_UNIT);
   localparam int O_HI  = h2clk(ONE_SPACE_MAX_H, CLK_PER_UNIT);
   localparam int SM_LO = h2clk(STOP_MARK_MIN_H, CLK_PER_UNIT);
   localparam int SM_HI = h2clk(STOP_MARK_MAX_H, CLK_PER_UNIT);
`ifdef IR_NEC_REPEAT_EN
   localparam int RS_LO = h2clk(REPEAT_SPACE_MIN_H, CLK_PER_UNIT);
   localparam int RS_HI = h2clk(REPEAT_SPACE_MAX_H, CLK_PER_UNIT);
`endif

   logic            fall, rise, line_lvl;
   logic [CW-1:0]   width;
   ir_state_t       state;
   logic [4:0]      bit_idx;
   logic [31:0]     shift_reg;
   logic            timeout;

   ir_input_sync u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .rx_port (rx_port),
      .fall    (fall),
      .rise    (rise),
      .level   (line_lvl)
   );

   function automatic logic in_win(input logic [CW-1:0] w, input int lo, input int hi);
      return (int'(w) >= lo) && (int'(w) <= hi);
   endfunction

   always_ff @(posedge clock) begin
      if (!reset_n || !rx_enable) begin
         width <= '0;
      end else if (fall || rise) begin
         width <= '0;
      end else if (width != CNT_MAX) begin
         width <= width + 1'b1;
      end
   end

   assign timeout = (width == CNT_MAX) && (state != IDLE);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         bit_idx   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_error  <= 1'b0;
`ifdef IR_NEC_REPEAT_EN
         rx_repeat <= 1'b0;
`endif
      end else begin
         rx_valid  <= 1'b0;
         rx_error  <= 1'b0;
`ifdef IR_NEC_REPEAT_EN
         rx_repeat <= 1'b0;
`endif
         if (!rx_enable) begin
            state   <= IDLE;
            bit_idx <= '0;
         end else if (timeout) begin
            rx_error <= 1'b1;
            state    <= IDLE;
         end else begin
            case (state)
               // Only a fresh fall starts a frame, so a line stuck low never re-triggers.
               IDLE: if (fall && !line_lvl) state <= LEAD_MARK;
               LEAD_MARK: if (rise) begin
                  if (in_win(width, LM_LO, LM_HI)) state <= LEAD_SPACE;
                  else begin rx_error <= 1'b1; state <= IDLE; end
               end
               LEAD_SPACE: if (fall) begin
                  if (in_win(width, LS_LO, LS_HI)) begin
                     state   <= BIT_MARK;
                     bit_idx <= '0;
                  end
`ifdef IR_NEC_REPEAT_EN
                  else if (in_win(width, RS_LO, RS_HI)) state <= STOP_MARK_REPEAT;
`endif
                  else begin rx_error <= 1'b1; state <= IDLE; end
               end
               BIT_MARK: if (rise) begin
                  if (in_win(width, BM_LO, BM_HI)) state <= BIT_SPACE;
                  else begin rx_error <= 1'b1; state <= IDLE; end
               end
               // The '0' window ends one clock below the start of the '1' window.
               BIT_SPACE: if (fall) begin
                  if (in_win(width, Z_LO, O_LO - 1) || in_win(width, O_LO, O_HI)) begin
                     shift_reg[bit_idx] <= in_win(width, O_LO, O_HI);
                     bit_idx            <= bit_idx + 1'b1;
                     state <= (bit_idx == 5'(FRAME_BITS - 1)) ? STOP_MARK : BIT_MARK;
                  end else begin
                     rx_error <= 1'b1;
                     state    <= IDLE;
                  end
               end
               STOP_MARK: if (rise) begin
                  if (in_win(width, SM_LO, SM_HI)) begin
                     rx_data  <= shift_reg;
                     rx_valid <= 1'b1;
                  end else begin
                     rx_error <= 1'b1;
                  end
                  state <= IDLE;
               end
               STOP_MARK_REPEAT: if (rise) begin
                  if (in_win(width, SM_LO, SM_HI)) begin
`ifdef IR_NEC_REPEAT_EN
                     rx_repeat <= 1'b1;
`endif
                  end else begin
                     rx_error <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
